keypad_matrix_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad and turns one debounced press into a 4-bit key code plus a one-clock valid strobe.
//  It is the input-side counterpart of the multiplexed 7-segment driver: it drives rows one at a time and reads
//  the columns, instead of driving digit commons and segments. Its Key_Code/Key_Valid feed the display/control logic.

---
 rtl/keypad_matrix_scanner.sv | 175 +++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low row strobe, debounces a single
// column hit on the scan tick and reports it as {row, col} with a one-clock valid.
module keypad_matrix_scanner #(
    parameter int SCAN_DIV       = 5000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       Sys_CLK,
    input  logic       Sys_RST,
    input  logic       EN,
    input  logic [3:0] COL,
    output logic [3:0] ROW,
    output logic [3:0] Key_Code,
    output logic       Key_Valid,
    output logic       Key_Down
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0] CNT_DONE = 4'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    function automatic logic single_low(input logic [3:0] col);
        logic hit;
        case (col)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] col);
        logic [1:0] idx;
        case (col)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    logic [3:0]       col_meta_r;
    logic [3:0]       col_sync_r;
    logic [DIV_W-1:0] div_r;
    logic             tick_s;
    state_t           state_r;
    logic [1:0]       row_idx_r;
    logic [1:0]       next_idx_s;
    logic [3:0]       pat_r;
    logic [3:0]       cnt_r;
    logic [3:0]       row_r;
    logic [3:0]       code_r;
    logic             valid_r;
    logic             down_r;

    assign tick_s     = EN && (div_r == DIV_MAX);
    assign next_idx_s = row_idx_r + 2'd1;

    assign ROW       = row_r;
    assign Key_Code  = code_r;
    assign Key_Valid = valid_r;
    assign Key_Down  = down_r;

    // Two-stage synchroniser for the asynchronous, pulled-up column inputs.
    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            col_meta_r <= 4'hF;
            col_sync_r <= 4'hF;
        end else begin
            col_meta_r <= COL;
            col_sync_r <= col_meta_r;
        end
    end

    // Scan-tick divider; held at zero while scanning is disabled.
    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            div_r <= '0;
        end else if (!EN) begin
            div_r <= '0;
        end else if (tick_s) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Scan / debounce / pressed state machine with registered keypad outputs.
    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            state_r   <= SCAN;
            row_idx_r <= 2'd0;
            row_r     <= 4'b1110;
            pat_r     <= 4'hF;
            cnt_r     <= 4'd0;
            code_r    <= 4'd0;
            valid_r   <= 1'b0;
            down_r    <= 1'b0;
        end else if (!EN) begin
            state_r   <= SCAN;
            row_idx_r <= 2'd0;
            row_r     <= 4'b1111;
            cnt_r     <= 4'd0;
            valid_r   <= 1'b0;
            down_r    <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            // Re-derive the strobe every cycle so it recovers from the released state after EN returns.
            row_r   <= row_drive(row_idx_r);
            case (state_r)
                SCAN: begin
                    if (tick_s) begin
                        if (single_low(col_sync_r)) begin
                            pat_r   <= col_sync_r;
                            cnt_r   <= 4'd1;
                            state_r <= DEBOUNCE;
                        end else begin
                            row_idx_r <= next_idx_s;
                            row_r     <= row_drive(next_idx_s);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (cnt_r == CNT_DONE) begin
                        code_r  <= {row_idx_r, col_index(pat_r)};
                        valid_r <= 1'b1;
                        down_r  <= 1'b1;
                        cnt_r   <= 4'd0;
                        state_r <= PRESSED;
                    end else if (tick_s) begin
                        if (col_sync_r == pat_r) begin
                            cnt_r <= cnt_r + 4'd1;
                        end else begin
                            cnt_r     <= 4'd0;
                            state_r   <= SCAN;
                            row_idx_r <= next_idx_s;
                            row_r     <= row_drive(next_idx_s);
                        end
                    end
                end
                PRESSED: begin
                    // Any column still low, including a second key, restarts the release count.
                    if (cnt_r == CNT_DONE) begin
                        down_r    <= 1'b0;
                        cnt_r     <= 4'd0;
                        state_r   <= SCAN;
                        row_idx_r <= next_idx_s;
                        row_r     <= row_drive(next_idx_s);
                    end else if (tick_s) begin
                        if (col_sync_r == 4'hF) begin
                            cnt_r <= cnt_r + 4'd1;
                        end else begin
                            cnt_r <= 4'd0;
                        end
                    end
                end
                default: begin
                    state_r <= SCAN;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner: table of {drive, cycles, expected outputs}
// records plus a hand-timed acceptance sequence, against a behavioural keypad.
module tb_keypad_matrix_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [15:0] keys = 16'h0000;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  code;
    logic        valid;
    logic        down;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    keypad_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
        .Sys_CLK  (clk),
        .Sys_RST  (rst),
        .EN       (en),
        .COL      (col),
        .ROW      (row),
        .Key_Code (code),
        .Key_Valid(valid),
        .Key_Down (down)
    );

    always #5 clk = ~clk;

    // Keypad: a held key (r,c) pulls column c low while row r is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (valid) pulses <= pulses + 1;
    end

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] keys;
        int          cycles;
        logic [3:0]  row;
        logic [3:0]  code;
        logic        down;
        int          pulses;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic e, input logic [15:0] k, input int n,
                       input logic [3:0] er, input logic [3:0] ec, input logic ed, input int ep);
        vec_t v;
        v.rst = r; v.en = e; v.keys = k; v.cycles = n;
        v.row = er; v.code = ec; v.down = ed; v.pulses = ep;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        // rst en keys     cyc  ROW      code   down  pulses
        add(1'b1, 1'b1, 16'h0000,  3, 4'b1110, 4'h0, 1'b0, 0); // reset state
        add(1'b0, 1'b1, 16'h0000,  3, 4'b1110, 4'h0, 1'b0, 0); // before first tick
        add(1'b0, 1'b1, 16'h0000,  1, 4'b1101, 4'h0, 1'b0, 0);
        add(1'b0, 1'b1, 16'h0000,  4, 4'b1011, 4'h0, 1'b0, 0);
        add(1'b0, 1'b1, 16'h0000,  4, 4'b0111, 4'h0, 1'b0, 0);
        add(1'b0, 1'b1, 16'h0000,  4, 4'b1110, 4'h0, 1'b0, 0); // wraps to row 0
        add(1'b0, 1'b1, 16'h0200, 24, 4'b1011, 4'h9, 1'b1, 1); // hold (2,1)
        add(1'b0, 1'b1, 16'h0000, 12, 4'b1011, 4'h9, 1'b1, 0); // release still pending
        add(1'b0, 1'b1, 16'h0000,  1, 4'b0111, 4'h9, 1'b0, 0); // release accepted, row 3
        add(1'b0, 1'b1, 16'h0000,  3, 4'b1110, 4'h9, 1'b0, 0);
        add(1'b0, 1'b1, 16'h0008,  4, 4'b1110, 4'h9, 1'b0, 0); // (0,3) detected, row held
        add(1'b0, 1'b1, 16'h0000,  4, 4'b1101, 4'h9, 1'b0, 0); // bounce rejected
        add(1'b0, 1'b1, 16'h0008, 28, 4'b1110, 4'h3, 1'b1, 1); // (0,3) held
        add(1'b0, 1'b1, 16'h0010, 28, 4'b1101, 4'h4, 1'b1, 1); // (1,0) held
        add(1'b0, 1'b1, 16'h0050, 16, 4'b1101, 4'h4, 1'b1, 0); // plus (1,2): ignored
        add(1'b0, 1'b1, 16'h0040, 16, 4'b1101, 4'h4, 1'b1, 0); // only (1,2) left
        add(1'b0, 1'b1, 16'h0000, 13, 4'b1011, 4'h4, 1'b0, 0); // both released
        add(1'b0, 1'b1, 16'h0050, 32, 4'b1011, 4'h4, 1'b0, 0); // two keys from idle
        add(1'b0, 1'b1, 16'h8000,  8, 4'b0111, 4'h4, 1'b0, 0); // (3,3) debouncing
        add(1'b0, 1'b0, 16'h8000,  1, 4'b1111, 4'h4, 1'b0, 0); // EN drop aborts
        add(1'b0, 1'b0, 16'h8000, 10, 4'b1111, 4'h4, 1'b0, 0);
        add(1'b0, 1'b1, 16'h0000,  1, 4'b1110, 4'h4, 1'b0, 0); // EN back: row 0
        add(1'b0, 1'b1, 16'h0000,  2, 4'b1110, 4'h4, 1'b0, 0);
        add(1'b0, 1'b1, 16'h0000,  1, 4'b1101, 4'h4, 1'b0, 0); // divider restarted
        add(1'b0, 1'b1, 16'h8000, 17, 4'b0111, 4'h4, 1'b0, 0); // (3,3) debouncing
        add(1'b1, 1'b1, 16'h8000,  1, 4'b1110, 4'h0, 1'b0, 0); // reset aborts
        add(1'b0, 1'b1, 16'h0000,  8, 4'b1011, 4'h0, 1'b0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            rst  = vq[i].rst;
            en   = vq[i].en;
            keys = vq[i].keys;
            p0   = pulses;
            step(vq[i].cycles);
            check($sformatf("v%0d_row", i),    int'(row),    int'(vq[i].row));
            check($sformatf("v%0d_code", i),   int'(code),   int'(vq[i].code));
            check($sformatf("v%0d_down", i),   int'(down),   int'(vq[i].down));
            check($sformatf("v%0d_pulses", i), pulses - p0,  vq[i].pulses);
        end

        // Exact acceptance latency: detect on a tick, two more matching ticks, accept one cycle later.
        keys = 16'h0200;
        step(12);
        check("lat_pre_valid", int'(valid), 0);
        check("lat_pre_down",  int'(down),  0);
        check("lat_pre_row",   int'(row),   int'(4'b1011));
        step(1);
        check("lat_valid",     int'(valid), 1);
        check("lat_code",      int'(code),  int'(4'h9));
        check("lat_down",      int'(down),  1);
        step(1);
        check("lat_post_valid", int'(valid), 0);
        check("lat_post_down",  int'(down),  1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
